// File: rtl/uart_wb_pkg.sv
// -----------------------------------------------------------------------------
// uart_wb_pkg
// Shared definitions for the UART-to-Wishbone debug bridge:
//   - frame opcodes and response bytes
//   - bridge FSM state encoding
//   - ceil_div8(): number of bytes needed to carry a field of given bit width
// -----------------------------------------------------------------------------
package uart_wb_pkg;

  localparam logic [7:0] OP_WRITE    = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ     = 8'h52;  // 'R'

  localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_TIMEOUT = 8'h54;  // 'T'
  localparam logic [7:0] RSP_ERR     = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_REQ,
    ST_WAIT,
    ST_SEND
  } state_t;

  function automatic int ceil_div8(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_wb_tx_shift.sv
// -----------------------------------------------------------------------------
// uart_wb_tx_shift
// Response serializer. Loads either a full DATA_BYTES word (read data) or a
// single status byte, then presents it MSB-first on a valid/ready byte port.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_load_word, i_word parallel load of DATA_BYTES bytes
//   i_load_byte, i_byte load of one byte
//   o_tx_data/o_tx_valid/i_tx_ready  byte stream towards the UART
//   o_done              high in the cycle the final byte is accepted
// -----------------------------------------------------------------------------
module uart_wb_tx_shift #(
  parameter int DATA_BYTES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load_word,
  input  logic                    i_load_byte,
  input  logic [8*DATA_BYTES-1:0] i_word,
  input  logic [7:0]              i_byte,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_done
);

  localparam int W  = 8 * DATA_BYTES;
  localparam int CW = $clog2(DATA_BYTES + 1);

  logic [W-1:0]  r_shift;
  logic [CW-1:0] r_left;
  logic          r_valid;
  logic          w_xfer;

  assign w_xfer     = r_valid && i_tx_ready;
  // Combinational so the parent FSM can leave SEND on the same edge the last
  // byte is taken.
  assign o_done     = w_xfer && (r_left == CW'(1));
  assign o_tx_data  = r_shift[W-1 -: 8];
  assign o_tx_valid = r_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
    end else if (i_load_word) begin
      r_shift <= i_word;
      r_left  <= CW'(DATA_BYTES);
      r_valid <= 1'b1;
    end else if (i_load_byte) begin
      // Single byte is parked in the top lane so it comes out first.
      r_shift <= W'(i_byte) << (W - 8);
      r_left  <= CW'(1);
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      r_shift <= r_shift << 8;
      r_left  <= r_left - 1'b1;
      if (r_left == CW'(1)) r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_wb_bridge.sv
// -----------------------------------------------------------------------------
// uart_wb_bridge
// Parses binary command frames from a UART byte stream and issues one
// pipelined Wishbone transaction per frame, returning 'K', read data, 'T'
// (bus timeout) or 'E' (bad opcode) on the UART transmit stream.
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_rx_data, i_rx_valid            received bytes (no back-pressure)
//   o_tx_data, o_tx_valid, i_tx_ready  response byte stream
//   o_wb_cyc/stb/we/addr/data/sel    Wishbone master request
//   i_wb_stall, i_wb_ack, i_wb_data  Wishbone slave response
//   o_overrun                        sticky: a byte arrived while busy on bus/tx
//   o_busy                           bridge is not idle
// -----------------------------------------------------------------------------
module uart_wb_bridge
  import uart_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_valid,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [ADDR_WIDTH-1:0]   o_wb_addr,
  output logic [DATA_WIDTH-1:0]   o_wb_data,
  output logic [DATA_WIDTH/8-1:0] o_wb_sel,
  input  logic                    i_wb_stall,
  input  logic                    i_wb_ack,
  input  logic [DATA_WIDTH-1:0]   i_wb_data,
  output logic                    o_overrun,
  output logic                    o_busy
);

  localparam int ADDR_BYTES = ceil_div8(ADDR_WIDTH);
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CNT_W      = $clog2(MAX_BYTES + 1);
  localparam int TMO_W      = $clog2(TIMEOUT_CYCLES);

  state_t                r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [TMO_W-1:0]      r_tmo;
  logic                  r_we, r_cyc, r_stb, r_overrun, r_busy;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  logic       w_cyc_next, w_stb_next;
  logic       w_load_word, w_load_byte, w_done;
  logic [7:0] w_rsp_byte;
  logic       w_is_op, w_last_addr, w_last_data, w_expired, w_rx_drop;

  assign w_is_op     = (i_rx_data == OP_WRITE) || (i_rx_data == OP_READ);
  assign w_last_addr = (r_cnt == CNT_W'(ADDR_BYTES - 1));
  assign w_last_data = (r_cnt == CNT_W'(DATA_BYTES - 1));
  assign w_expired   = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_rx_drop   = i_rx_valid &&
                       (r_state == ST_REQ || r_state == ST_WAIT || r_state == ST_SEND);

  assign o_wb_cyc  = r_cyc;
  assign o_wb_stb  = r_stb;
  assign o_wb_we   = r_we;
  assign o_wb_addr = r_addr;
  assign o_wb_data = r_data;
  assign o_wb_sel  = {DATA_BYTES{1'b1}};
  assign o_overrun = r_overrun;
  assign o_busy    = r_busy;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cyc_next   = r_cyc;
    w_stb_next   = r_stb;
    w_load_word  = 1'b0;
    w_load_byte  = 1'b0;
    w_rsp_byte   = RSP_OK;
    unique case (r_state)
      ST_IDLE: begin
        if (i_rx_valid) begin
          if (w_is_op) begin
            w_state_next = ST_ADDR;
          end else begin
            w_load_byte  = 1'b1;
            w_rsp_byte   = RSP_ERR;
            w_state_next = ST_SEND;
          end
        end
      end
      ST_ADDR: begin
        if (i_rx_valid && w_last_addr) begin
          if (r_we) begin
            w_state_next = ST_DATA;
          end else begin
            w_state_next = ST_REQ;
            w_cyc_next   = 1'b1;
            w_stb_next   = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (i_rx_valid && w_last_data) begin
          w_state_next = ST_REQ;
          w_cyc_next   = 1'b1;
          w_stb_next   = 1'b1;
        end
      end
      ST_REQ, ST_WAIT: begin
        // An ack counts only once the strobe has been accepted; in REQ that
        // means the same cycle as !stall. Ack beats timeout in the expiry cycle.
        if (i_wb_ack && (r_state == ST_WAIT || !i_wb_stall)) begin
          w_cyc_next   = 1'b0;
          w_stb_next   = 1'b0;
          w_state_next = ST_SEND;
          if (r_we) w_load_byte = 1'b1;
          else      w_load_word = 1'b1;
        end else if (w_expired) begin
          w_cyc_next   = 1'b0;
          w_stb_next   = 1'b0;
          w_load_byte  = 1'b1;
          w_rsp_byte   = RSP_TIMEOUT;
          w_state_next = ST_SEND;
        end else if (r_state == ST_REQ && !i_wb_stall) begin
          w_stb_next   = 1'b0;
          w_state_next = ST_WAIT;
        end
      end
      ST_SEND: begin
        if (w_done) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_we      <= 1'b0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      r_cyc  <= w_cyc_next;
      r_stb  <= w_stb_next;
      r_busy <= (w_state_next != ST_IDLE);
      // Zero outside the bus phase, so it always starts from 0 on REQ entry.
      r_tmo  <= (r_state == ST_REQ || r_state == ST_WAIT) ? r_tmo + 1'b1 : '0;
      if (w_rx_drop) r_overrun <= 1'b1;
      if (r_state == ST_IDLE && i_rx_valid && w_is_op) begin
        r_we  <= (i_rx_data == OP_WRITE);
        r_cnt <= '0;
      end
      if (r_state == ST_ADDR && i_rx_valid) begin
        // Truncating shift drops the unused high bits of the first byte.
        r_addr <= ADDR_WIDTH'({r_addr, i_rx_data});
        r_cnt  <= w_last_addr ? '0 : r_cnt + 1'b1;
      end
      if (r_state == ST_DATA && i_rx_valid) begin
        r_data <= DATA_WIDTH'({r_data, i_rx_data});
        r_cnt  <= w_last_data ? '0 : r_cnt + 1'b1;
      end
    end
  end

  uart_wb_tx_shift #(
    .DATA_BYTES (DATA_BYTES)
  ) u_tx_shift (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load_word (w_load_word),
    .i_load_byte (w_load_byte),
    .i_word      (i_wb_data),
    .i_byte      (w_rsp_byte),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .o_done      (w_done)
  );

endmodule

// File: tb/tb_uart_wb_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_wb_bridge
// Directed bench: a 32/32 bridge (TIMEOUT_CYCLES=16) for the main scenarios and
// a 14/128 bridge for the wide-data read.
// -----------------------------------------------------------------------------
module tb_uart_wb_bridge;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  // 32/32 instance
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        cyc, stb, we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        stall, ack;
  logic [31:0] rdata;
  logic        overrun, busy;

  // 14/128 instance
  logic [7:0]   b_rx_data;
  logic         b_rx_valid;
  logic [7:0]   b_tx_data;
  logic         b_tx_valid;
  logic         b_tx_ready;
  logic         b_cyc, b_stb, b_we;
  logic [13:0]  b_addr;
  logic [127:0] b_wdata;
  logic [15:0]  b_sel;
  logic         b_stall, b_ack;
  logic [127:0] b_rdata;
  logic         b_overrun, b_busy;

  uart_wb_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_wb_cyc   (cyc),
    .o_wb_stb   (stb),
    .o_wb_we    (we),
    .o_wb_addr  (addr),
    .o_wb_data  (wdata),
    .o_wb_sel   (sel),
    .i_wb_stall (stall),
    .i_wb_ack   (ack),
    .i_wb_data  (rdata),
    .o_overrun  (overrun),
    .o_busy     (busy)
  );

  uart_wb_bridge #(
    .ADDR_WIDTH     (14),
    .DATA_WIDTH     (128),
    .TIMEOUT_CYCLES (16)
  ) dut_wide (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (b_rx_data),
    .i_rx_valid (b_rx_valid),
    .o_tx_data  (b_tx_data),
    .o_tx_valid (b_tx_valid),
    .i_tx_ready (b_tx_ready),
    .o_wb_cyc   (b_cyc),
    .o_wb_stb   (b_stb),
    .o_wb_we    (b_we),
    .o_wb_addr  (b_addr),
    .o_wb_data  (b_wdata),
    .o_wb_sel   (b_sel),
    .i_wb_stall (b_stall),
    .i_wb_ack   (b_ack),
    .i_wb_data  (b_rdata),
    .o_overrun  (b_overrun),
    .o_busy     (b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_byte_b(input logic [7:0] b);
    b_rx_data  = b;
    b_rx_valid = 1'b1;
    step();
    b_rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_total++;
    if ({cyc, stb, we, tx_valid, overrun, busy} !== 6'b0)
      $display("FAIL rst_ctrl got %b want 000000", {cyc, stb, we, tx_valid, overrun, busy});
    else n_pass++;
    n_total++;
    if (addr !== 32'h0) $display("FAIL rst_addr got %h want 0", addr); else n_pass++;
    n_total++;
    if (wdata !== 32'h0) $display("FAIL rst_data got %h want 0", wdata); else n_pass++;
    n_total++;
    if (tx_data !== 8'h0) $display("FAIL rst_txdata got %h want 0", tx_data); else n_pass++;
    n_total++;
    if (sel !== 4'hF) $display("FAIL rst_sel got %h want f", sel); else n_pass++;
    n_total++;
    if ({b_cyc, b_busy, b_tx_valid, b_sel} !== {3'b000, 16'hFFFF})
      $display("FAIL rst_wide got %b want 000ffff", {b_cyc, b_busy, b_tx_valid, b_sel});
    else n_pass++;
  endtask

  task automatic test_write();
    logic [7:0] frame [9];
    frame = '{8'h57, 8'h00, 8'h00, 8'h01, 8'h20, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 9; i++) send_byte(frame[i]);
    n_total++;
    if ({cyc, stb, we} !== 3'b111) $display("FAIL wr_req got %b want 111", {cyc, stb, we});
    else n_pass++;
    n_total++;
    if (addr !== 32'h0000_0120) $display("FAIL wr_addr got %h want 00000120", addr); else n_pass++;
    n_total++;
    if (wdata !== 32'hDEAD_BEEF) $display("FAIL wr_data got %h want deadbeef", wdata); else n_pass++;
    n_total++;
    if (sel !== 4'hF) $display("FAIL wr_sel got %h want f", sel); else n_pass++;
    step();
    n_total++;
    if ({cyc, stb} !== 2'b10) $display("FAIL wr_wait got %b want 10", {cyc, stb}); else n_pass++;
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_total++;
    if ({cyc, tx_valid, tx_data} !== {1'b0, 1'b1, 8'h4B})
      $display("FAIL wr_rsp got cyc=%b v=%b d=%h want 0 1 4b", cyc, tx_valid, tx_data);
    else n_pass++;
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    n_total++;
    if ({tx_valid, busy} !== 2'b00) $display("FAIL wr_idle got %b want 00", {tx_valid, busy});
    else n_pass++;
  endtask

  task automatic test_read_ready_toggle();
    logic [7:0] frame [5];
    frame = '{8'h52, 8'h00, 8'h00, 8'h01, 8'h20};
    for (int i = 0; i < 5; i++) send_byte(frame[i]);
    n_total++;
    if ({cyc, stb, we, addr} !== {3'b110, 32'h0000_0120})
      $display("FAIL rd_req got %b %h want 110 00000120", {cyc, stb, we}, addr);
    else n_pass++;
    // Ack in the same cycle the strobe is accepted.
    ack   = 1'b1;
    rdata = 32'hDEAD_BEEF;
    step();
    ack   = 1'b0;
    rdata = 32'h0;
    n_total++;
    if ({cyc, tx_valid, tx_data} !== {1'b0, 1'b1, 8'hDE})
      $display("FAIL rd_b0 got cyc=%b v=%b d=%h want 0 1 de", cyc, tx_valid, tx_data);
    else n_pass++;
    tx_ready = 1'b1;
    step();
    n_total++;
    if (tx_data !== 8'hAD) $display("FAIL rd_b1 got %h want ad", tx_data); else n_pass++;
    tx_ready = 1'b0;
    step();
    n_total++;
    if ({tx_valid, tx_data} !== {1'b1, 8'hAD})
      $display("FAIL rd_hold got v=%b d=%h want 1 ad", tx_valid, tx_data);
    else n_pass++;
    tx_ready = 1'b1;
    step();
    n_total++;
    if (tx_data !== 8'hBE) $display("FAIL rd_b2 got %h want be", tx_data); else n_pass++;
    step();
    n_total++;
    if ({tx_valid, tx_data} !== {1'b1, 8'hEF})
      $display("FAIL rd_b3 got v=%b d=%h want 1 ef", tx_valid, tx_data);
    else n_pass++;
    step();
    tx_ready = 1'b0;
    n_total++;
    if ({tx_valid, busy} !== 2'b00) $display("FAIL rd_idle got %b want 00", {tx_valid, busy});
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [7:0] frame [9];
    int acc;
    acc   = 0;
    frame = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 9; i++) send_byte(frame[i]);
    stall = 1'b1;
    if (stb && !stall) acc++;
    for (int i = 0; i < 5; i++) begin
      step();
      n_total++;
      if ({cyc, stb, addr, wdata} !== {2'b11, 32'h0000_0010, 32'h1122_3344})
        $display("FAIL stall_hold%0d got %b %h %h", i, {cyc, stb}, addr, wdata);
      else n_pass++;
      if (stb && !stall) acc++;
    end
    stall = 1'b0;
    if (stb && !stall) acc++;
    step();
    if (stb && !stall) acc++;
    step();
    n_total++;
    if ({cyc, stb} !== 2'b10) $display("FAIL stall_wait got %b want 10", {cyc, stb}); else n_pass++;
    if (stb && !stall) acc++;
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_total++;
    if ({cyc, tx_valid, tx_data} !== {1'b0, 1'b1, 8'h4B})
      $display("FAIL stall_rsp got cyc=%b v=%b d=%h want 0 1 4b", cyc, tx_valid, tx_data);
    else n_pass++;
    n_total++;
    if (acc != 1) $display("FAIL stall_accepts got %0d want 1", acc); else n_pass++;
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL stall_idle got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [7:0] frame [5];
    int n;
    frame = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h04};
    for (int i = 0; i < 5; i++) send_byte(frame[i]);
    n = 0;
    while (cyc === 1'b1 && n < 40) begin
      step();
      n++;
    end
    n_total++;
    if (n != 16) $display("FAIL tmo_cycles got %0d want 16", n); else n_pass++;
    n_total++;
    if ({stb, tx_valid, tx_data} !== {1'b0, 1'b1, 8'h54})
      $display("FAIL tmo_rsp got stb=%b v=%b d=%h want 0 1 54", stb, tx_valid, tx_data);
    else n_pass++;
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    n_total++;
    if ({busy, tx_valid} !== 2'b00) $display("FAIL tmo_idle got %b want 00", {busy, tx_valid});
    else n_pass++;
  endtask

  task automatic test_bad_opcode();
    send_byte(8'h41);
    n_total++;
    if ({cyc, stb, tx_valid, tx_data} !== {3'b001, 8'h45})
      $display("FAIL badop_rsp got %b %h want 001 45", {cyc, stb, tx_valid}, tx_data);
    else n_pass++;
    step();
    n_total++;
    if ({cyc, tx_valid, tx_data} !== {2'b01, 8'h45})
      $display("FAIL badop_hold got %b %h want 01 45", {cyc, tx_valid}, tx_data);
    else n_pass++;
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    n_total++;
    if ({busy, tx_valid, overrun} !== 3'b000)
      $display("FAIL badop_idle got %b want 000", {busy, tx_valid, overrun});
    else n_pass++;
  endtask

  task automatic test_overrun();
    logic [7:0] frame [5];
    logic [7:0] exp_b [4];
    frame = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h08};
    exp_b = '{8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < 5; i++) send_byte(frame[i]);
    step();
    send_byte(8'h57);
    n_total++;
    if ({overrun, cyc, stb} !== 3'b110)
      $display("FAIL ovr_flag got %b want 110", {overrun, cyc, stb});
    else n_pass++;
    ack   = 1'b1;
    rdata = 32'h1234_5678;
    step();
    ack   = 1'b0;
    rdata = 32'h0;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({tx_valid, tx_data} !== {1'b1, exp_b[i]})
        $display("FAIL ovr_b%0d got v=%b d=%h want 1 %h", i, tx_valid, tx_data, exp_b[i]);
      else n_pass++;
      step();
    end
    tx_ready = 1'b0;
    step();
    n_total++;
    if ({busy, tx_valid, overrun, cyc} !== 4'b0010)
      $display("FAIL ovr_end got %b want 0010", {busy, tx_valid, overrun, cyc});
    else n_pass++;
  endtask

  task automatic test_wide_read();
    logic [7:0] exp_b;
    send_byte_b(8'h52);
    send_byte_b(8'hFF);
    send_byte_b(8'hFF);
    n_total++;
    if ({b_cyc, b_stb, b_we, b_addr} !== {3'b110, 14'h3FFF})
      $display("FAIL wide_req got %b %h want 110 3fff", {b_cyc, b_stb, b_we}, b_addr);
    else n_pass++;
    step();
    b_ack   = 1'b1;
    b_rdata = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    step();
    b_ack   = 1'b0;
    b_rdata = '0;
    b_tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_b = 8'(i * 17);
      n_total++;
      if ({b_tx_valid, b_tx_data} !== {1'b1, exp_b})
        $display("FAIL wide_b%0d got v=%b d=%h want 1 %h", i, b_tx_valid, b_tx_data, exp_b);
      else n_pass++;
      step();
    end
    b_tx_ready = 1'b0;
    n_total++;
    if ({b_busy, b_tx_valid, b_cyc, b_overrun, b_wdata} !== {4'b0000, 128'h0})
      $display("FAIL wide_end got %b %h want 0000 0", {b_busy, b_tx_valid, b_cyc, b_overrun}, b_wdata);
    else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    n_pass     = 0;
    n_total    = 0;
    rst        = 1'b1;
    rx_data    = 8'h0;
    rx_valid   = 1'b0;
    tx_ready   = 1'b0;
    stall      = 1'b0;
    ack        = 1'b0;
    rdata      = 32'h0;
    b_rx_data  = 8'h0;
    b_rx_valid = 1'b0;
    b_tx_ready = 1'b0;
    b_stall    = 1'b0;
    b_ack      = 1'b0;
    b_rdata    = '0;
    step();
    test_reset();
    test_write();
    test_read_ready_toggle();
    test_stall();
    test_timeout();
    test_bad_opcode();
    test_overrun();
    test_wide_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_wb_bridge.md
# uart_wb_bridge

Parametrised UART-byte-stream to pipelined-Wishbone master bridge for board bring-up and debug of the DDR3 controller. It parses binary read/write command frames of configurable address and data width from the UART receive stream and issues one Wishbone transaction per frame. It returns write acknowledgements or read data over the UART transmit stream. A bus timeout aborts hung transactions. It sits between the `uart` instance and the controller's first Wishbone port, replacing single-letter ASCII poking.

## Interface
- `ADDR_WIDTH`, 32: Wishbone address width; `ADDR_BYTES = ceil(ADDR_WIDTH/8)`.
- `DATA_WIDTH`, 32: Wishbone data width; multiple of 8; `DATA_BYTES = DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, 1024: max cycles from `o_wb_stb` first assertion to `i_wb_ack`; ≥ 2.

Ports:
- `i_clk` in 1: single clock; all logic on rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_rx_data` in 8: received byte.
- `i_rx_valid` in 1: one-cycle pulse per byte; no back-pressure exists.
- `o_tx_data` out 8: byte to transmit.
- `o_tx_valid` out 1: transmit byte valid.
- `i_tx_ready` in 1: UART accepts `o_tx_data`.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1 each: Wishbone cycle, strobe, write-enable.
- `o_wb_addr` out ADDR_WIDTH: word address.
- `o_wb_data` out DATA_WIDTH: write data.
- `o_wb_sel` out DATA_BYTES: always all ones.
- `i_wb_stall`, `i_wb_ack` in 1 each: Wishbone stall, acknowledge.
- `i_wb_data` in DATA_WIDTH: read data.
- `o_overrun` out 1: sticky; a byte was dropped.
- `o_busy` out 1: state ≠ IDLE.

## Operation
- Frames are MSB-first. Write is `0x57 'W'`, then ADDR_BYTES address bytes, then DATA_BYTES data bytes. Read is `0x52 'R'`, then ADDR_BYTES address bytes.
- Address bytes shift into a register; the upper `8*ADDR_BYTES-ADDR_WIDTH` bits of the first byte are discarded.
- Responses:
  - Write acked: `0x4B 'K'`.
  - Read acked: DATA_BYTES bytes of `i_wb_data`, captured on ack, MSB first.
  - Timeout: `0x54 'T'`.
  - Any other opcode byte in IDLE: `0x45 'E'`.
- States:
  - IDLE: on `0x57`/`0x52` latch `we` and go to ADDR. On any other byte, load `'E'` and go to SEND.
  - ADDR: count ADDR_BYTES bytes. After the last byte, go to DATA if write, else to REQ.
  - DATA: count DATA_BYTES bytes, then go to REQ.
  - REQ: `cyc=stb=1`; hold stb, addr, data and we stable while `i_wb_stall`. On `!i_wb_stall`, go to WAIT; stb drops the next cycle.
  - WAIT: `cyc=1`, `stb=0`. On `i_wb_ack`, capture data, drop cyc, and go to SEND.
  - SEND: shift out the response bytes, then go to IDLE.
- An `i_wb_ack` seen in REQ in the same cycle as `!i_wb_stall` completes the transaction directly; the bridge goes to SEND without entering WAIT.
- Timeout: the counter starts at REQ entry and counts in REQ and WAIT. When it reaches TIMEOUT_CYCLES-1 with no ack, the bridge drops `cyc` and `stb` on the next edge, loads `'T'`, and goes to SEND. An ack in the expiry cycle counts as success.
- Overrun: `i_rx_valid` in REQ, WAIT or SEND drops the byte and sets `o_overrun` until reset. The frame in progress completes normally.
- There is no inter-byte timeout; a partial frame waits indefinitely.

## Timing
- Reset values: state IDLE; `o_wb_cyc`, `o_wb_stb`, `o_wb_we`, `o_tx_valid`, `o_overrun`, `o_busy` all 0; `o_wb_addr`, `o_wb_data`, `o_tx_data` all 0; `o_wb_sel` all ones.
- Frame to bus: `o_wb_cyc` and `o_wb_stb` assert on the edge after the final frame byte's `i_rx_valid`.
- Ack to transmit: `o_tx_valid` asserts on the edge after `i_wb_ack`.
- Transmit handshake:
  - `o_tx_data` is stable while `o_tx_valid && !i_tx_ready`.
  - A byte transfers on `o_tx_valid && i_tx_ready`.
  - The next byte is presented on the following edge, so back-to-back transfers are possible.
- The bridge returns to IDLE on the edge after the last byte transfers.
- A new opcode is accepted one cycle after `o_busy` falls.
- Reset asserted mid-transaction drops `cyc`, `stb` and `tx_valid` on that edge, with no response.
- Only one transaction is outstanding at a time.
- All outputs are registered.

## Structure
- The package `uart_wb_pkg` holds:
  - opcode constants `OP_WRITE`/`OP_READ`;
  - response constants `RSP_OK`/`RSP_TIMEOUT`/`RSP_ERR`;
  - the state enum;
  - the function `ceil_div8`.
- One sub-module, `uart_wb_tx_shift`:
  - parallel-load of DATA_BYTES bytes or a single byte;
  - the valid/ready serializer;
  - a `done` pulse.
- The byte counter, timeout counter and Wishbone FSM live in the top module.

## Test plan
All scenarios use ADDR_WIDTH=32, DATA_WIDTH=32 unless stated.
- Write frame 57 00 00 01 20 DE AD BE EF with slave ack 2 cycles after the request is accepted -> one write cycle with addr 0x00000120, data 0xDEADBEEF, sel 0xF and we=1; then tx 0x4B.
- Read frame 52 00 00 01 20 with slave returning 0xDEADBEEF; `i_tx_ready` toggled 1-0-1 -> tx sequence DE AD BE EF; data is stable during ready-low.
- `i_wb_stall` high for 5 cycles -> stb, addr and data are held stable; exactly one accepted strobe; `cyc` stays high until ack.
- Slave never acks, TIMEOUT_CYCLES=16 -> `cyc` drops 16 cycles after stb is first asserted; tx 0x54; bridge back in IDLE.
- Opcode byte 0x41 in IDLE -> tx 0x45 with no bus activity. A byte injected during WAIT -> `o_overrun`=1 and the current read still returns correct data.
- ADDR_WIDTH=14, DATA_WIDTH=128: read frame 52 FF FF -> addr 0x3FFF; 16 response bytes returned MSB first.
